el2_ifu_vec_replay_chk: RTL and testbench

- Synthesizable, parametrised vector-replay checker for IFU datapath blocks such as the compressed-instruction expander. Feeds the DUT and checks its outputs so the check runs identically in simulation, emulation and FPGA.
- Reads paired stimulus/expected vectors from an external 1-cycle-latency memory, drives LANES stimulus words per cycle into the DUT, and aligns expected values to a pipelined DUT of DUT_LAT cycles.
- Compares results, counts mismatches and captures the first failure. Optional stop-on-error mode.

---
 rtl/el2_ifu_vec_replay_chk.sv | 199 +++++++++++++++++++
 tb/tb_el2_ifu_vec_replay_chk.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_ifu_vec_replay_chk.sv
// rtl/el2_ifu_vec_replay_chk.sv - vector-replay checker for pipelined IFU datapath blocks
module el2_ifu_vec_replay_chk #(
    parameter int LANES   = 1,
    parameter int DIN_W   = 16,
    parameter int DOUT_W  = 32,
    parameter int ADDR_W  = 17,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 16,
    localparam int LW     = $clog2(LANES) + 1
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         num_vec,
    input  logic                      stop_on_err,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [LANES*DIN_W-1:0]    mem_rd_din,
    input  logic [LANES*DOUT_W-1:0]   mem_rd_exp,
    output logic [LANES*DIN_W-1:0]    dut_din,
    output logic                      dut_valid,
    input  logic [LANES*DOUT_W-1:0]   dut_dout,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_W-1:0]          err_cnt,
    output logic [ADDR_W-1:0]         first_err_idx,
    output logic [LW-1:0]             first_err_lane,
    output logic [DOUT_W-1:0]         first_err_act,
    output logic [DOUT_W-1:0]         first_err_exp
);

    localparam int SW = ((ERR_W > LW) ? ERR_W : LW) + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                                 state_q, state_d;
    logic [ADDR_W-1:0]                      addr_q, addr_d;
    logic [ADDR_W-1:0]                      num_q;
    logic                                   stop_q;
    logic                                   load;

    logic                                   rd_pend_q;
    logic [ADDR_W-1:0]                      rd_idx_q;
    logic [LANES*DIN_W-1:0]                 din_q;
    // Stage 0 lines up with dut_din; stage DUT_LAT lines up with dut_dout.
    logic [DUT_LAT:0]                       v_q;
    logic [DUT_LAT:0][LANES*DOUT_W-1:0]     exp_q;
    logic [DUT_LAT:0][ADDR_W-1:0]           idx_q;

    logic [ERR_W-1:0]                       err_q, err_d;
    logic [ADDR_W-1:0]                      fe_idx_q;
    logic [LW-1:0]                          fe_lane_q;
    logic [DOUT_W-1:0]                      fe_act_q, fe_exp_q;

    logic [LANES-1:0]                       fail_vec;
    logic [LW-1:0]                          fail_cnt;
    logic                                   cap_hit;
    logic [LW-1:0]                          cap_lane;
    logic [DOUT_W-1:0]                      cap_act, cap_exp;
    logic [SW-1:0]                          err_sum;
    logic                                   abort;
    logic                                   pipe_busy;

    always_comb begin
        fail_vec = '0;
        fail_cnt = '0;
        cap_hit  = 1'b0;
        cap_lane = '0;
        cap_act  = '0;
        cap_exp  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (v_q[DUT_LAT] &&
                (dut_dout[l*DOUT_W +: DOUT_W] != exp_q[DUT_LAT][l*DOUT_W +: DOUT_W])) begin
                fail_vec[l] = 1'b1;
                fail_cnt    = fail_cnt + LW'(1);
                if (!cap_hit) begin
                    cap_hit  = 1'b1;
                    cap_lane = LW'(l);
                    cap_act  = dut_dout[l*DOUT_W +: DOUT_W];
                    cap_exp  = exp_q[DUT_LAT][l*DOUT_W +: DOUT_W];
                end
            end
        end
    end

    assign err_sum   = SW'(err_q) + SW'(fail_cnt);
    assign err_d     = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
    assign abort     = stop_q && (|fail_vec);
    assign pipe_busy = rd_pend_q || (|v_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    addr_d  = '0;
                    state_d = (num_vec == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                addr_d = addr_q + ADDR_W'(1);
                if (abort || (addr_q == num_q - ADDR_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // An abort flushes the pipeline at this edge, so DONE follows one cycle later.
                if (!abort && !pipe_busy) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            num_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (load) begin
                num_q  <= num_vec;
                stop_q <= stop_on_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            din_q     <= '0;
            v_q       <= '0;
            exp_q     <= '0;
            idx_q     <= '0;
        end else begin
            rd_pend_q <= mem_rd_en && !abort;
            rd_idx_q  <= addr_q;
            v_q[0]    <= rd_pend_q && !abort;
            if (rd_pend_q) begin
                din_q    <= mem_rd_din;
                exp_q[0] <= mem_rd_exp;
                idx_q[0] <= rd_idx_q;
            end
            for (int i = 1; i <= DUT_LAT; i++) begin
                v_q[i]   <= v_q[i-1] && !abort;
                exp_q[i] <= exp_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_q     <= '0;
            fe_idx_q  <= '0;
            fe_lane_q <= '0;
            fe_act_q  <= '0;
            fe_exp_q  <= '0;
        end else if (load) begin
            err_q     <= '0;
            fe_idx_q  <= '0;
            fe_lane_q <= '0;
            fe_act_q  <= '0;
            fe_exp_q  <= '0;
        end else begin
            err_q <= err_d;
            if ((err_q == '0) && cap_hit) begin
                fe_idx_q  <= idx_q[DUT_LAT];
                fe_lane_q <= cap_lane;
                fe_act_q  <= cap_act;
                fe_exp_q  <= cap_exp;
            end
        end
    end

    assign mem_rd_en      = (state_q == S_RUN);
    assign mem_rd_addr    = addr_q;
    assign dut_din        = din_q;
    assign dut_valid      = v_q[0];
    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign pass           = (state_q == S_DONE) && (err_q == '0);
    assign err_cnt        = err_q;
    assign first_err_idx  = fe_idx_q;
    assign first_err_lane = fe_lane_q;
    assign first_err_act  = fe_act_q;
    assign first_err_exp  = fe_exp_q;

endmodule

// File: tb/tb_el2_ifu_vec_replay_chk.sv
// tb/tb_el2_ifu_vec_replay_chk.sv - scoreboard bench for el2_ifu_vec_replay_chk
module tb_el2_ifu_vec_replay_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_l;

    // Instance A: LANES=1, DUT_LAT=0, ERR_W=16
    logic        start_a, stop_a, rd_en_a, val_a, busy_a, done_a, pass_a;
    logic [16:0] num_a, rd_addr_a, fidx_a;
    logic [15:0] rd_din_a, din_a, err_a;
    logic [31:0] rd_exp_a, dout_a, fact_a, fexp_a;
    logic [0:0]  flane_a;

    // Instance B: LANES=2, DUT_LAT=2, ERR_W=2
    logic        start_b, stop_b, rd_en_b, val_b, busy_b, done_b, pass_b;
    logic [16:0] num_b, rd_addr_b, fidx_b;
    logic [31:0] rd_din_b, din_b, fact_b, fexp_b;
    logic [63:0] rd_exp_b, dout_b, p1_b, p2_b;
    logic [1:0]  err_b, flane_b;

    el2_ifu_vec_replay_chk #(.LANES(1), .DIN_W(16), .DOUT_W(32), .ADDR_W(17), .DUT_LAT(0), .ERR_W(16)) u_a (
        .clk(clk), .rst_l(rst_l), .start(start_a), .num_vec(num_a), .stop_on_err(stop_a),
        .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a), .mem_rd_din(rd_din_a), .mem_rd_exp(rd_exp_a),
        .dut_din(din_a), .dut_valid(val_a), .dut_dout(dout_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_a), .first_err_idx(fidx_a), .first_err_lane(flane_a),
        .first_err_act(fact_a), .first_err_exp(fexp_a));

    el2_ifu_vec_replay_chk #(.LANES(2), .DIN_W(16), .DOUT_W(32), .ADDR_W(17), .DUT_LAT(2), .ERR_W(2)) u_b (
        .clk(clk), .rst_l(rst_l), .start(start_b), .num_vec(num_b), .stop_on_err(stop_b),
        .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b), .mem_rd_din(rd_din_b), .mem_rd_exp(rd_exp_b),
        .dut_din(din_b), .dut_valid(val_b), .dut_dout(dout_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_b), .first_err_idx(fidx_b), .first_err_lane(flane_b),
        .first_err_act(fact_b), .first_err_exp(fexp_b));

    logic [15:0] stim_a [0:31];
    logic [31:0] mexp_a [0:31];
    logic [31:0] stim_b [0:31];
    logic [63:0] mexp_b [0:31];
    logic [16:0] rd_log_a[$];
    logic [16:0] rd_log_b[$];

    initial begin
        rd_din_a = '0; rd_exp_a = '0; rd_din_b = '0; rd_exp_b = '0; p1_b = '0; p2_b = '0;
    end

    always @(posedge clk) begin
        if (rd_en_a) begin
            rd_din_a <= stim_a[rd_addr_a[4:0]];
            rd_exp_a <= mexp_a[rd_addr_a[4:0]];
            rd_log_a.push_back(rd_addr_a);
        end
        if (rd_en_b) begin
            rd_din_b <= stim_b[rd_addr_b[4:0]];
            rd_exp_b <= mexp_b[rd_addr_b[4:0]];
            rd_log_b.push_back(rd_addr_b);
        end
        p1_b <= {16'h0, din_b[31:16], 16'h0, din_b[15:0]};
        p2_b <= p1_b;
    end

    assign dout_a = {16'h0, din_a};
    assign dout_b = p2_b;

    typedef struct {
        logic [15:0] err;
        logic        pass;
        logic [16:0] idx;
        logic [1:0]  lane;
        logic [31:0] act;
        logic [31:0] exp;
        int          lat;
    } res_t;

    res_t        sb[$];
    logic [16:0] exp_addr[$];
    int checks = 0;
    int failures = 0;

    task automatic init_mem();
        for (int i = 0; i < 32; i++) begin
            stim_a[i] = 16'(16'h4500 + i);
            mexp_a[i] = {16'h0, 16'(16'h4500 + i)};
            stim_b[i] = {16'(16'h5100 + i), 16'(16'h5000 + i)};
            mexp_b[i] = {16'h0, 16'(16'h5100 + i), 16'h0, 16'(16'h5000 + i)};
        end
    endtask

    task automatic run_a(input logic [16:0] n, input logic stop, output int lat);
        rd_log_a.delete();
        @(negedge clk);
        start_a = 1'b1; num_a = n; stop_a = stop;
        @(posedge clk); #1;
        start_a = 1'b0; num_a = 17'h1ffff; stop_a = ~stop;
        lat = -1;
        if (done_a) lat = 0;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (done_a) lat = k;
        end
    endtask

    task automatic run_b(input logic [16:0] n, output int lat);
        rd_log_b.delete();
        @(negedge clk);
        start_b = 1'b1; num_b = n; stop_b = 1'b0;
        @(posedge clk); #1;
        start_b = 1'b0; num_b = 17'h3;
        lat = -1;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (done_b) lat = k;
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        start_a = 0; stop_a = 0; num_a = 0; start_b = 0; stop_b = 0; num_b = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy_a, done_a, pass_a, rd_en_a, val_a} !== 5'b0) begin failures++; $display("FAIL reset_ctl_a got=%b want=00000", {busy_a, done_a, pass_a, rd_en_a, val_a}); end
        checks++; if ({err_a, fidx_a, din_a, rd_addr_a} !== '0) begin failures++; $display("FAIL reset_data_a got=%h want=0", {err_a, fidx_a, din_a, rd_addr_a}); end
        checks++; if ({busy_b, done_b, pass_b, rd_en_b, val_b, err_b} !== '0) begin failures++; $display("FAIL reset_b got=%b want=0", {busy_b, done_b, pass_b, rd_en_b, val_b, err_b}); end
        @(negedge clk); rst_l = 1'b1;
        @(negedge clk);
        checks++; if ({busy_a, done_a, rd_en_a} !== 3'b0) begin failures++; $display("FAIL post_reset_idle got=%b want=000", {busy_a, done_a, rd_en_a}); end
    endtask

    task automatic test_clean_run();
        int lat; res_t r;
        init_mem();
        for (int i = 0; i < 4; i++) exp_addr.push_back(17'(i));
        sb.push_back('{err: 16'd0, pass: 1'b1, idx: 17'd0, lane: 2'd0, act: 32'd0, exp: 32'd0, lat: 7});
        run_a(17'd4, 1'b0, lat);
        r = sb.pop_front();
        checks++; if (lat != r.lat) begin failures++; $display("FAIL clean_latency got=%0d want=%0d", lat, r.lat); end
        checks++; if (pass_a !== r.pass || err_a !== r.err) begin failures++; $display("FAIL clean_result pass=%b err=%0d want pass=%b err=%0d", pass_a, err_a, r.pass, r.err); end
        checks++; if (rd_log_a.size() != exp_addr.size()) begin failures++; $display("FAIL clean_read_count got=%0d want=%0d", rd_log_a.size(), exp_addr.size()); end
        while (exp_addr.size() > 0 && rd_log_a.size() > 0) begin
            logic [16:0] e, g;
            e = exp_addr.pop_front(); g = rd_log_a.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL clean_read_addr got=%0d want=%0d", g, e); end
        end
        exp_addr.delete();
    endtask

    task automatic test_single_err();
        int lat; res_t r;
        init_mem();
        mexp_a[2] = 32'h0000_4501;
        sb.push_back('{err: 16'd1, pass: 1'b0, idx: 17'd2, lane: 2'd0, act: 32'h0000_4502, exp: 32'h0000_4501, lat: 7});
        run_a(17'd4, 1'b0, lat);
        r = sb.pop_front();
        checks++; if (lat != r.lat) begin failures++; $display("FAIL single_latency got=%0d want=%0d", lat, r.lat); end
        checks++; if (err_a !== r.err || pass_a !== r.pass) begin failures++; $display("FAIL single_cnt err=%0d pass=%b want err=%0d pass=%b", err_a, pass_a, r.err, r.pass); end
        checks++; if (fidx_a !== r.idx || {1'b0, flane_a} !== r.lane) begin failures++; $display("FAIL single_where idx=%0d lane=%0d want idx=%0d lane=%0d", fidx_a, flane_a, r.idx, r.lane); end
        checks++; if (fact_a !== r.act || fexp_a !== r.exp) begin failures++; $display("FAIL single_vals act=%h exp=%h want act=%h exp=%h", fact_a, fexp_a, r.act, r.exp); end
    endtask

    task automatic test_two_lane_lat();
        int lat; res_t r;
        init_mem();
        mexp_b[1] = mexp_b[1] ^ {32'h1, 32'h1};
        sb.push_back('{err: 16'd2, pass: 1'b0, idx: 17'd1, lane: 2'd0, act: 32'h0000_5001, exp: 32'h0000_5000, lat: 8});
        run_b(17'd3, lat);
        r = sb.pop_front();
        checks++; if (lat != r.lat) begin failures++; $display("FAIL lanes_latency got=%0d want=%0d", lat, r.lat); end
        checks++; if ({14'b0, err_b} !== r.err || pass_b !== r.pass) begin failures++; $display("FAIL lanes_cnt err=%0d pass=%b want err=%0d pass=%b", err_b, pass_b, r.err, r.pass); end
        checks++; if (fidx_b !== r.idx || flane_b !== r.lane) begin failures++; $display("FAIL lanes_where idx=%0d lane=%0d want idx=%0d lane=%0d", fidx_b, flane_b, r.idx, r.lane); end
        checks++; if (fact_b !== r.act || fexp_b !== r.exp) begin failures++; $display("FAIL lanes_vals act=%h exp=%h want act=%h exp=%h", fact_b, fexp_b, r.act, r.exp); end
    endtask

    task automatic test_stop_on_err();
        int lat; res_t r; logic [16:0] mx;
        init_mem();
        mexp_a[3] = mexp_a[3] ^ 32'h1;
        mexp_a[6] = mexp_a[6] ^ 32'h1;
        sb.push_back('{err: 16'd1, pass: 1'b0, idx: 17'd3, lane: 2'd0, act: 32'h0000_4503, exp: 32'h0000_4502, lat: 7});
        run_a(17'd10, 1'b1, lat);
        r = sb.pop_front();
        mx = '0;
        foreach (rd_log_a[i]) if (rd_log_a[i] > mx) mx = rd_log_a[i];
        checks++; if (lat != r.lat) begin failures++; $display("FAIL stop_latency got=%0d want=%0d", lat, r.lat); end
        checks++; if (err_a !== r.err || pass_a !== r.pass) begin failures++; $display("FAIL stop_cnt err=%0d pass=%b want err=%0d pass=%b", err_a, pass_a, r.err, r.pass); end
        checks++; if (fidx_a !== r.idx || fact_a !== r.act) begin failures++; $display("FAIL stop_first idx=%0d act=%h want idx=%0d act=%h", fidx_a, fact_a, r.idx, r.act); end
        checks++; if (mx > 17'd5 || rd_log_a.size() < 4) begin failures++; $display("FAIL stop_reads max_addr=%0d count=%0d want max<=5 count>=4", mx, rd_log_a.size()); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rd_en_a !== 1'b0 || done_a !== 1'b1 || err_a !== 16'd1) begin failures++; $display("FAIL stop_hold rd_en=%b done=%b err=%0d want 0 1 1", rd_en_a, done_a, err_a); end
    endtask

    task automatic test_saturate();
        int lat; res_t r;
        init_mem();
        for (int i = 0; i < 6; i++) mexp_b[i] = mexp_b[i] ^ 64'h1;
        sb.push_back('{err: 16'd3, pass: 1'b0, idx: 17'd0, lane: 2'd0, act: 32'h0000_5000, exp: 32'h0000_5001, lat: 11});
        run_b(17'd6, lat);
        r = sb.pop_front();
        checks++; if (lat != r.lat) begin failures++; $display("FAIL sat_latency got=%0d want=%0d", lat, r.lat); end
        checks++; if ({14'b0, err_b} !== r.err || pass_b !== r.pass) begin failures++; $display("FAIL sat_cnt err=%0d pass=%b want err=%0d pass=%b", err_b, pass_b, r.err, r.pass); end
        checks++; if (fidx_b !== r.idx || fexp_b !== r.exp) begin failures++; $display("FAIL sat_first idx=%0d exp=%h want idx=%0d exp=%h", fidx_b, fexp_b, r.idx, r.exp); end
    endtask

    task automatic test_zero_vec();
        int lat; res_t r;
        init_mem();
        sb.push_back('{err: 16'd0, pass: 1'b1, idx: 17'd0, lane: 2'd0, act: 32'd0, exp: 32'd0, lat: 0});
        run_a(17'd0, 1'b0, lat);
        r = sb.pop_front();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (lat != r.lat) begin failures++; $display("FAIL zero_latency got=%0d want=%0d", lat, r.lat); end
        checks++; if (pass_a !== r.pass || err_a !== r.err || fidx_a !== r.idx) begin failures++; $display("FAIL zero_result pass=%b err=%0d idx=%0d want 1 0 0", pass_a, err_a, fidx_a); end
        checks++; if (rd_log_a.size() != 0) begin failures++; $display("FAIL zero_reads got=%0d want=0", rd_log_a.size()); end
    endtask

    task automatic test_reset_mid_run();
        int lat; bit hit; res_t r;
        init_mem();
        mexp_a[1] = mexp_a[1] ^ 32'h1;
        @(negedge clk);
        start_a = 1'b1; num_a = 17'd10; stop_a = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0;
        hit = 0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            if (rd_en_a && rd_addr_a == 17'd5) hit = 1;
        end
        checks++; if (!hit || err_a !== 16'd1) begin failures++; $display("FAIL mid_reach hit=%0d err=%0d want hit=1 err=1", hit, err_a); end
        #2 rst_l = 1'b0;
        #1;
        checks++; if ({busy_a, done_a, pass_a, rd_en_a, val_a} !== 5'b0) begin failures++; $display("FAIL mid_async_ctl got=%b want=00000", {busy_a, done_a, pass_a, rd_en_a, val_a}); end
        checks++; if ({err_a, fidx_a, fact_a, rd_addr_a} !== '0) begin failures++; $display("FAIL mid_async_data got=%h want=0", {err_a, fidx_a, fact_a, rd_addr_a}); end
        @(negedge clk); @(negedge clk); rst_l = 1'b1;
        init_mem();
        sb.push_back('{err: 16'd0, pass: 1'b1, idx: 17'd0, lane: 2'd0, act: 32'd0, exp: 32'd0, lat: 7});
        run_a(17'd4, 1'b0, lat);
        r = sb.pop_front();
        checks++; if (lat != r.lat || pass_a !== r.pass || err_a !== r.err) begin failures++; $display("FAIL mid_rerun lat=%0d pass=%b err=%0d want lat=%0d pass=1 err=0", lat, pass_a, err_a, r.lat); end
        checks++; if (rd_log_a.size() != 4 || rd_log_a[0] !== 17'd0 || rd_log_a[3] !== 17'd3) begin failures++; $display("FAIL mid_rerun_reads count=%0d want 4 reads 0..3", rd_log_a.size()); end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_single_err();
        test_two_lane_lat();
        test_stop_on_err();
        test_saturate();
        test_zero_vec();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
